idex_pipe_reg: RTL and testbench

//  ID/EX pipeline register of the 5-stage RV32I core. Captures decoded ID-stage fields each cycle.

---
 rtl/idex_pipe_reg_if.sv | 69 ++++++
 rtl/idex_pipe_reg.sv | 124 ++++++++++++
 tb/tb_idex_pipe_reg.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/idex_pipe_reg_if.sv
// ID/EX bundle: decoded ID fields in, registered IDEX fields out.
// master = ID/HDU/EX side, slave = the pipeline register.
interface idex_pipe_reg_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [2:0]      id_funct3;
  logic            id_funct7_5;
  logic [3:0]      id_alu_op;
  logic            id_alu_src;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_reg_write;
  logic            id_mem_to_reg;
  logic            id_branch;

  logic            ex_valid;
  logic [XLEN-1:0] IDEX_pc;
  logic [4:0]      IDEX_rs1;
  logic [4:0]      IDEX_rs2;
  logic [4:0]      IDEX_rd;
  logic [XLEN-1:0] IDEX_rs1_data;
  logic [XLEN-1:0] IDEX_rs2_data;
  logic [XLEN-1:0] IDEX_imm;
  logic [2:0]      IDEX_funct3;
  logic            IDEX_funct7_5;
  logic [3:0]      IDEX_alu_op;
  logic            IDEX_alu_src;
  logic            IDEX_MemRead;
  logic            IDEX_MemWrite;
  logic            IDEX_RegWrite;
  logic            IDEX_MemToReg;
  logic            IDEX_Branch;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd,
    output id_rs1_data, id_rs2_data, id_imm,
    output id_funct3, id_funct7_5, id_alu_op,
    output id_alu_src, id_mem_read, id_mem_write,
    output id_reg_write, id_mem_to_reg, id_branch,
    input  ex_valid, IDEX_pc, IDEX_rs1, IDEX_rs2,
    input  IDEX_rd, IDEX_rs1_data, IDEX_rs2_data,
    input  IDEX_imm, IDEX_funct3, IDEX_funct7_5,
    input  IDEX_alu_op, IDEX_alu_src, IDEX_MemRead,
    input  IDEX_MemWrite, IDEX_RegWrite,
    input  IDEX_MemToReg, IDEX_Branch
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd,
    input  id_rs1_data, id_rs2_data, id_imm,
    input  id_funct3, id_funct7_5, id_alu_op,
    input  id_alu_src, id_mem_read, id_mem_write,
    input  id_reg_write, id_mem_to_reg, id_branch,
    output ex_valid, IDEX_pc, IDEX_rs1, IDEX_rs2,
    output IDEX_rd, IDEX_rs1_data, IDEX_rs2_data,
    output IDEX_imm, IDEX_funct3, IDEX_funct7_5,
    output IDEX_alu_op, IDEX_alu_src, IDEX_MemRead,
    output IDEX_MemWrite, IDEX_RegWrite,
    output IDEX_MemToReg, IDEX_Branch
  );
endinterface

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: capture / bubble / hold with WB bypass.
// Ports: clk, rst, hold, flush, stall, wb_*, bus (slave), bubble/flush counters.
module idex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             stall,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  idex_pipe_reg_if.slave   bus,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
  } idex_t;

  idex_t            st_q, st_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             byp1, byp2, ctl_en;

  // x0 is never bypassed so it keeps reading as zero
  assign byp1 = wb_reg_write && (wb_rd != 5'd0)
             && (wb_rd == bus.id_rs1);
  assign byp2 = wb_reg_write && (wb_rd != 5'd0)
             && (wb_rd == bus.id_rs2);

  always_comb begin
    st_d         = st_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    ctl_en       = 1'b0;
    if (!hold) begin
      // data fields always follow ID; only valid/ctrl/regs get gated
      st_d.pc       = bus.id_pc;
      st_d.imm      = bus.id_imm;
      st_d.funct3   = bus.id_funct3;
      st_d.funct7_5 = bus.id_funct7_5;
      st_d.alu_op   = bus.id_alu_op;
      st_d.alu_src  = bus.id_alu_src;
      st_d.rs1_data = byp1 ? wb_data : bus.id_rs1_data;
      st_d.rs2_data = byp2 ? wb_data : bus.id_rs2_data;
      if (flush || stall) begin
        st_d.rs1 = 5'd0;
        st_d.rs2 = 5'd0;
      end else begin
        st_d.rs1 = bus.id_rs1;
        st_d.rs2 = bus.id_rs2;
        ctl_en   = bus.id_valid;
      end
      st_d.valid      = ctl_en;
      st_d.rd         = ctl_en ? bus.id_rd : 5'd0;
      st_d.mem_read   = ctl_en & bus.id_mem_read;
      st_d.mem_write  = ctl_en & bus.id_mem_write;
      st_d.reg_write  = ctl_en & bus.id_reg_write;
      st_d.mem_to_reg = ctl_en & bus.id_mem_to_reg;
      st_d.branch     = ctl_en & bus.id_branch;
      // flush wins the count when both request a bubble
      if (flush) begin
        if (flush_cnt_q != '1)
          flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (stall) begin
        if (bubble_cnt_q != '1)
          bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      st_q         <= st_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.ex_valid      = st_q.valid;
  assign bus.IDEX_pc       = st_q.pc;
  assign bus.IDEX_rs1      = st_q.rs1;
  assign bus.IDEX_rs2      = st_q.rs2;
  assign bus.IDEX_rd       = st_q.rd;
  assign bus.IDEX_rs1_data = st_q.rs1_data;
  assign bus.IDEX_rs2_data = st_q.rs2_data;
  assign bus.IDEX_imm      = st_q.imm;
  assign bus.IDEX_funct3   = st_q.funct3;
  assign bus.IDEX_funct7_5 = st_q.funct7_5;
  assign bus.IDEX_alu_op   = st_q.alu_op;
  assign bus.IDEX_alu_src  = st_q.alu_src;
  assign bus.IDEX_MemRead  = st_q.mem_read;
  assign bus.IDEX_MemWrite = st_q.mem_write;
  assign bus.IDEX_RegWrite = st_q.reg_write;
  assign bus.IDEX_MemToReg = st_q.mem_to_reg;
  assign bus.IDEX_Branch   = st_q.branch;
  assign bubble_cnt        = bubble_cnt_q;
  assign flush_cnt         = flush_cnt_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg (CNT_W=4).
// Linear steps; outputs sampled 1 time unit after each rising edge.
module tb_idex_pipe_reg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, hold, flush, stall;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;
  int               checks = 0;
  int               failures = 0;

  idex_pipe_reg_if #(.XLEN(XLEN)) bif ();

  idex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .flush        (flush),
    .stall        (stall),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .bus          (bif),
    .bubble_cnt   (bubble_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v,
                        input logic [31:0] pc,
                        input logic [4:0] r1,
                        input logic [4:0] r2,
                        input logic [4:0] rd,
                        input logic mr,
                        input logic rw,
                        input logic m2r);
    bif.id_valid      = v;
    bif.id_pc         = pc;
    bif.id_rs1        = r1;
    bif.id_rs2        = r2;
    bif.id_rd         = rd;
    bif.id_mem_read   = mr;
    bif.id_reg_write  = rw;
    bif.id_mem_to_reg = m2r;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    flush = 1'b0; stall = 1'b0;
    wb_reg_write = 1'b0; wb_rd = 5'd0;
    wb_data = '0;
    set_id(1'b1, 32'h50, 5'd1, 5'd1, 5'd9,
           1'b1, 1'b1, 1'b1);
    bif.id_rs1_data  = 32'h1;
    bif.id_rs2_data  = 32'h2;
    bif.id_imm       = 32'h0;
    bif.id_funct3    = 3'd0;
    bif.id_funct7_5  = 1'b0;
    bif.id_alu_op    = 4'd0;
    bif.id_alu_src   = 1'b0;
    bif.id_mem_write = 1'b0;
    bif.id_branch    = 1'b0;

    step();
    chk("rst_valid", bif.ex_valid, 0);
    chk("rst_rd", bif.IDEX_rd, 0);
    chk("rst_memread", bif.IDEX_MemRead, 0);
    chk("rst_pc", bif.IDEX_pc, 0);
    chk("rst_bcnt", bubble_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    rst = 1'b0;

    // load-use: lw x2,0(x2) then add x4,x3,x2
    set_id(1'b1, 32'h100, 5'd2, 5'd0, 5'd2,
           1'b1, 1'b1, 1'b1);
    step();
    chk("lw_memread", bif.IDEX_MemRead, 1);
    chk("lw_rd", bif.IDEX_rd, 2);
    chk("lw_valid", bif.ex_valid, 1);
    chk("lw_pc", bif.IDEX_pc, 32'h100);

    set_id(1'b1, 32'h104, 5'd3, 5'd2, 5'd4,
           1'b0, 1'b1, 1'b0);
    stall = 1'b1;
    step();
    chk("stl_memread", bif.IDEX_MemRead, 0);
    chk("stl_rd", bif.IDEX_rd, 0);
    chk("stl_valid", bif.ex_valid, 0);
    chk("stl_regwr", bif.IDEX_RegWrite, 0);
    chk("stl_bcnt", bubble_cnt, 1);

    stall = 1'b0;
    step();
    chk("add_rd", bif.IDEX_rd, 4);
    chk("add_rs2", bif.IDEX_rs2, 2);
    chk("add_rs1", bif.IDEX_rs1, 3);
    chk("add_valid", bif.ex_valid, 1);

    // flush and stall together: one bubble, counted as flush
    flush = 1'b1; stall = 1'b1;
    step();
    chk("fs_valid", bif.ex_valid, 0);
    chk("fs_rd", bif.IDEX_rd, 0);
    chk("fs_fcnt", flush_cnt, 1);
    chk("fs_bcnt", bubble_cnt, 1);

    // hold freezes everything, even with flush asserted
    flush = 1'b0; stall = 1'b0;
    set_id(1'b1, 32'h200, 5'd6, 5'd7, 5'd5,
           1'b0, 1'b1, 1'b0);
    step();
    chk("pre_hold_pc", bif.IDEX_pc, 32'h200);
    hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h300 + 32'(i), 5'd8, 5'd9,
             5'd7, 1'b1, 1'b0, 1'b1);
      step();
    end
    chk("hold_pc", bif.IDEX_pc, 32'h200);
    chk("hold_rd", bif.IDEX_rd, 5);
    chk("hold_valid", bif.ex_valid, 1);
    chk("hold_memread", bif.IDEX_MemRead, 0);
    chk("hold_fcnt", flush_cnt, 1);
    chk("hold_bcnt", bubble_cnt, 1);
    hold = 1'b0; flush = 1'b0;
    step();
    chk("rel_pc", bif.IDEX_pc, 32'h302);
    chk("rel_rd", bif.IDEX_rd, 7);
    chk("rel_memread", bif.IDEX_MemRead, 1);

    // WB bypass into rs2; rs1 = x0 untouched
    set_id(1'b1, 32'h400, 5'd0, 5'd2, 5'd3,
           1'b0, 1'b1, 1'b0);
    bif.id_rs1_data = 32'h55;
    bif.id_rs2_data = 32'h11;
    wb_reg_write = 1'b1; wb_rd = 5'd2;
    wb_data = 32'hDEADBEEF;
    step();
    chk("byp_rs2", bif.IDEX_rs2_data, 32'hDEADBEEF);
    chk("byp_rs1", bif.IDEX_rs1_data, 32'h55);

    // wb_rd = x0 never bypasses; invalid slot drops ctrl
    wb_rd = 5'd0;
    set_id(1'b0, 32'h404, 5'd0, 5'd2, 5'd6,
           1'b1, 1'b1, 1'b1);
    step();
    chk("x0_rs1", bif.IDEX_rs1_data, 32'h55);
    chk("x0_rs2", bif.IDEX_rs2_data, 32'h11);
    chk("inv_valid", bif.ex_valid, 0);
    chk("inv_rd", bif.IDEX_rd, 0);
    chk("inv_memread", bif.IDEX_MemRead, 0);
    wb_reg_write = 1'b0;

    // saturation: bubble_cnt starts at 1, 20 stalls
    stall = 1'b1;
    for (int i = 0; i < 13; i++) step();
    chk("sat_14", bubble_cnt, 14);
    step();
    chk("sat_15", bubble_cnt, 15);
    for (int i = 0; i < 6; i++) step();
    chk("sat_hold15", bubble_cnt, 15);
    chk("sat_fcnt", flush_cnt, 1);

    // mid-stream reset beats stall and flush
    set_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd3,
           1'b1, 1'b1, 1'b1);
    stall = 1'b0;
    step();
    chk("pre_rst_valid", bif.ex_valid, 1);
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    chk("mrst_valid", bif.ex_valid, 0);
    chk("mrst_rd", bif.IDEX_rd, 0);
    chk("mrst_pc", bif.IDEX_pc, 0);
    chk("mrst_memread", bif.IDEX_MemRead, 0);
    chk("mrst_bcnt", bubble_cnt, 0);
    chk("mrst_fcnt", flush_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
